// File: rtl/alu.sv
// RV32I integer execute unit: decodes a one-hot instruction vector (lowest set
// bit wins) and registers one 32-bit result per clock.
module alu (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] rs1,
   input  logic [31:0] rs2,
   input  logic [11:0] imm,
   input  logic [31:0] PC,
   input  logic [38:0] instructions,
   output logic [31:0] ALUoutput
);

   typedef enum logic [5:0] {
      OP_ADD,  OP_SUB,  OP_XOR,  OP_OR,   OP_AND,  OP_SLL,  OP_SRL,  OP_SRA,
      OP_SLT,  OP_SLTU, OP_ADDI, OP_XORI, OP_ORI,  OP_ANDI, OP_SLLI, OP_SRLI,
      OP_SRAI, OP_SLTI, OP_SLTIU,
      OP_LB,   OP_LH,   OP_LW,   OP_LBU,  OP_LHU,
      OP_SB,   OP_SH,   OP_SW,
      OP_BEQ,  OP_BNE,  OP_BLT,  OP_BGE,  OP_BLTU, OP_BGEU,
      OP_JAL,  OP_JALR, OP_LUI,  OP_AUIPC, OP_ECALL, OP_EBREAK,
      OP_NONE = 6'd63
   } op_e;

   op_e         op;
   logic [31:0] imm_sx;
   logic [31:0] upper_imm;
   logic [31:0] mem_addr;
   logic [31:0] link;
   logic [31:0] result;

   assign imm_sx    = {{20{imm[11]}}, imm};
   assign upper_imm = {imm, 20'h0};
   assign mem_addr  = rs1 + imm_sx;
   assign link      = PC + 32'd4;

   // Scan from the top down so the lowest set bit is the last one written.
   // NOTE: every variable assigned in always_comb gets a default first, so no
   // path through the block can leave it unassigned and infer a latch.
   always_comb begin
      op = OP_NONE;
      for (int i = 38; i >= 0; i--) begin
         if (instructions[i]) op = op_e'(6'(i));
      end
   end

   always_comb begin
      result = '0;
      case (op)
         OP_ADD:   result = rs1 + rs2;
         OP_SUB:   result = rs1 - rs2;
         OP_XOR:   result = rs1 ^ rs2;
         OP_OR:    result = rs1 | rs2;
         OP_AND:   result = rs1 & rs2;
         OP_SLL:   result = rs1 << rs2[4:0];
         OP_SRL:   result = rs1 >> rs2[4:0];
         OP_SRA:   result = $signed(rs1) >>> rs2[4:0];
         OP_SLT:   result = {31'd0, $signed(rs1) < $signed(rs2)};
         OP_SLTU:  result = {31'd0, rs1 < rs2};
         OP_ADDI:  result = mem_addr;
         OP_XORI:  result = rs1 ^ imm_sx;
         OP_ORI:   result = rs1 | imm_sx;
         OP_ANDI:  result = rs1 & imm_sx;
         OP_SLLI:  result = rs1 << imm[4:0];
         OP_SRLI:  result = rs1 >> imm[4:0];
         OP_SRAI:  result = $signed(rs1) >>> imm[4:0];
         OP_SLTI:  result = {31'd0, $signed(rs1) < $signed(imm_sx)};
         OP_SLTIU: result = {31'd0, rs1 < imm_sx};
         OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
         OP_SB, OP_SH, OP_SW:
                   result = mem_addr;
         OP_BEQ:   result = {31'd0, rs1 == rs2};
         OP_BNE:   result = {31'd0, rs1 != rs2};
         OP_BLT:   result = {31'd0, $signed(rs1) < $signed(rs2)};
         OP_BGE:   result = {31'd0, $signed(rs1) >= $signed(rs2)};
         OP_BLTU:  result = {31'd0, rs1 < rs2};
         OP_BGEU:  result = {31'd0, rs1 >= rs2};
         OP_JAL, OP_JALR:
                   result = link;
         OP_LUI:   result = upper_imm;
         OP_AUIPC: result = PC + upper_imm;
         default:  result = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples its inputs at the same edge regardless of statement order.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) ALUoutput <= '0;
      else     ALUoutput <= result;
   end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed spec vectors plus randomized operations
// compared against an arithmetic reference model.
module tb_alu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] rs1, rs2, PC;
   logic [11:0] imm;
   logic [38:0] instructions;
   logic [31:0] ALUoutput;

   int n_checks = 0;
   int n_fails  = 0;

   localparam longint TWO32 = 64'sd4294967296;

   alu dut (
      .clk          (clk),
      .rst          (rst),
      .rs1          (rs1),
      .rs2          (rs2),
      .imm          (imm),
      .PC           (PC),
      .instructions (instructions),
      .ALUoutput    (ALUoutput)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic longint uval(input logic [31:0] x);
      return longint'({32'h0, x});
   endfunction

   function automatic longint sval(input logic [31:0] x);
      return x[31] ? uval(x) - TWO32 : uval(x);
   endfunction

   function automatic logic [31:0] wrap(input longint v);
      logic [63:0] t;
      t = v;
      return t[31:0];
   endfunction

   function automatic longint floor_div(input longint v, input longint d);
      if (v >= 0) return v / d;
      return -((-v + d - 1) / d);
   endfunction

   function automatic logic [31:0] flag(input bit c);
      return c ? 32'd1 : 32'd0;
   endfunction

   // Reference model: picks the lowest set bit, then evaluates the operation
   // with plain integer arithmetic on mathematical (64-bit) values.
   function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b,
                                         input logic [11:0] im, input logic [31:0] pc,
                                         input logic [38:0] ins);
      int          k = -1;
      longint      ua, ub, sa, sb, si, upc, pw_b, pw_i;
      logic [31:0] ui;
      for (int i = 0; i < 39; i++) begin
         if (ins[i]) begin
            k = i;
            break;
         end
      end
      ua   = uval(a);
      ub   = uval(b);
      sa   = sval(a);
      sb   = sval(b);
      upc  = uval(pc);
      si   = im[11] ? longint'({52'h0, im}) - 4096 : longint'({52'h0, im});
      ui   = wrap(si);
      pw_b = longint'(1) << (ub % 32);
      pw_i = longint'(1) << (longint'({52'h0, im}) % 32);
      case (k)
         0:  return wrap(ua + ub);
         1:  return wrap(ua - ub);
         2:  return a ^ b;
         3:  return a | b;
         4:  return a & b;
         5:  return wrap(ua * pw_b);
         6:  return wrap(ua / pw_b);
         7:  return wrap(floor_div(sa, pw_b));
         8:  return flag(sa < sb);
         9:  return flag(ua < ub);
         10: return wrap(ua + si);
         11: return a ^ ui;
         12: return a | ui;
         13: return a & ui;
         14: return wrap(ua * pw_i);
         15: return wrap(ua / pw_i);
         16: return wrap(floor_div(sa, pw_i));
         17: return flag(sa < si);
         18: return flag(ua < uval(ui));
         19, 20, 21, 22, 23, 24, 25, 26: return wrap(ua + si);
         27: return flag(ua == ub);
         28: return flag(ua != ub);
         29: return flag(sa < sb);
         30: return flag(sa >= sb);
         31: return flag(ua < ub);
         32: return flag(ua >= ub);
         33, 34: return wrap(upc + 4);
         35: return wrap(uval({20'h0, im}) * 1048576);
         36: return wrap(upc + uval({20'h0, im}) * 1048576);
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [38:0] bit_of(input int idx);
      logic [38:0] one;
      one = 39'd1;
      return one << idx;
   endfunction

   // Drive one operation just after a rising edge and check it after the next.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic [11:0] im,
                         input logic [31:0] pc, input logic [38:0] ins,
                         input logic [31:0] exp, input string tag);
      rs1          = a;
      rs2          = b;
      imm          = im;
      PC           = pc;
      instructions = ins;
      @(posedge clk);
      #1;
      check(tag, ALUoutput, exp);
   endtask

   initial begin
      logic [31:0] a, b, pc;
      logic [11:0] im;
      logic [38:0] ins;
      int          idx;

      rst = 1'b1; rs1 = '0; rs2 = '0; imm = '0; PC = '0; instructions = '0;
      #1;
      check("reset_value", ALUoutput, 32'd0);
      #11;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("bubble_after_reset", ALUoutput, 32'd0);

      // Asynchronous reset between edges
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(0), 32'd9, "add_before_rst");
      #3;
      rst = 1'b1;
      #1;
      check("rst_async", ALUoutput, 32'd0);
      @(negedge clk);
      instructions = '0;
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("rst_release_bubble", ALUoutput, 32'd0);

      // Pending result discarded by reset
      rs1 = 32'd5; rs2 = 32'd4; instructions = bit_of(0);
      #2;
      rst = 1'b1;
      @(posedge clk);
      #1;
      check("rst_discard", ALUoutput, 32'd0);
      rst = 1'b0;

      // Register-register ops on 5/4
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(0),  32'd9,  "add");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(1),  32'd1,  "sub");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(2),  32'd1,  "xor");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(3),  32'd5,  "or");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(4),  32'd4,  "and");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(5),  32'd80, "sll");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(6),  32'd0,  "srl");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(7),  32'd0,  "sra");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(8),  32'd0,  "slt");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(9),  32'd0,  "sltu");
      // Immediate ops
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(10), 32'd17,    "addi");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(11), 32'd9,     "xori");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(12), 32'd13,    "ori");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(13), 32'd4,     "andi");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(14), 32'd20480, "slli");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(15), 32'd0,     "srli");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(16), 32'd0,     "srai");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(17), 32'd1,     "slti");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(18), 32'd1,     "sltiu");
      // Address, branch, jump and upper-immediate ops
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(19), 32'd17, "lb_addr");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(24), 32'd17, "sb_addr");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(27), 32'd0,  "beq");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(28), 32'd1,  "bne");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(29), 32'd0,  "blt");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(30), 32'd1,  "bge");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(31), 32'd0,  "bltu");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(32), 32'd1,  "bgeu");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(33), 32'd6,  "jal");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(34), 32'd6,  "jalr");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(35), 32'h00C0_0000, "lui");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(36), 32'h00C0_0002, "auipc");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(37), 32'd0,  "ecall");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(38), 32'd0,  "ebreak");

      // Signed boundary cases
      run_op(32'hFFFF_FFF0, 32'd4, 12'd0, 32'd0, bit_of(7),  32'hFFFF_FFFF, "sra_neg");
      run_op(32'hFFFF_FFF0, 32'd4, 12'd0, 32'd0, bit_of(6),  32'h0FFF_FFFF, "srl_neg");
      run_op(32'hFFFF_FFF0, 32'd4, 12'd0, 32'd0, bit_of(8),  32'd1, "slt_neg");
      run_op(32'hFFFF_FFF0, 32'd4, 12'd0, 32'd0, bit_of(9),  32'd0, "sltu_neg");
      run_op(32'hFFFF_FFF0, 32'd4, 12'd0, 32'd0, bit_of(29), 32'd1, "blt_neg");
      run_op(32'hFFFF_FFF0, 32'd4, 12'd0, 32'd0, bit_of(31), 32'd0, "bltu_neg");
      run_op(32'd0, 32'd0, 12'hFFF, 32'd0, bit_of(10), 32'hFFFF_FFFF, "addi_neg_imm");
      run_op(32'd0, 32'd0, 12'hFFF, 32'd0, bit_of(18), 32'd1,         "sltiu_neg_imm");
      run_op(32'h8000_0000, 32'h7FFF_FFFF, 12'd0, 32'd0, bit_of(8), 32'd1, "slt_minint");
      run_op(32'h8000_0000, 32'h7FFF_FFFF, 12'd0, 32'd0, bit_of(9), 32'd0, "sltu_minint");
      run_op(32'h8000_0001, 32'd0,  12'd0, 32'd0, bit_of(7), 32'h8000_0001, "sra_by0");
      run_op(32'h8000_0001, 32'd32, 12'd0, 32'd0, bit_of(5), 32'h8000_0001, "sll_by32_low5");
      run_op(32'h8000_0000, 32'd0, 12'h7E4, 32'd0, bit_of(16), 32'hF800_0000, "srai_hi_ignored");

      // Wrap-around and priority
      run_op(32'hFFFF_FFFF, 32'd1, 12'd0, 32'd0, bit_of(0), 32'd0, "add_wrap");
      run_op(32'd0, 32'd0, 12'd0, 32'hFFFF_FFFC, bit_of(33), 32'd0, "jal_wrap");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, 39'h3, 32'd9, "prio_add_sub");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, bit_of(36) | bit_of(38), 32'h00C0_0002, "prio_auipc");
      run_op(32'd5, 32'd4, 12'd12, 32'd2, 39'd0, 32'd0, "bubble");

      // Randomized operations, back to back
      for (int n = 0; n < 400; n++) begin
         a  = $urandom;
         b  = $urandom;
         im = 12'($urandom);
         pc = $urandom;
         case ($urandom_range(0, 7))
            0: a = 32'h8000_0000;
            1: b = a;
            2: b = 32'($urandom_range(0, 40));
            3: pc = 32'hFFFF_FFFC;
            default: ;
         endcase
         idx = int'($urandom_range(0, 39));
         ins = (idx == 39) ? 39'd0 : bit_of(idx);
         if ($urandom_range(0, 4) == 0) ins = ins | bit_of(int'($urandom_range(0, 38)));
         run_op(a, b, im, pc, ins, model(a, b, im, pc, ins), $sformatf("rand%0d_ins%010h", n, ins));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
